// File: rtl/turret_aim_ctrl_if.sv
// Bundle of keyboard, timebase, motion-table and aim-output signals for turret_aim_ctrl.
// master: keyboard/table side; slave: the aim controller.
interface turret_aim_ctrl_if #(
    parameter int unsigned N_ANGLES = 9,
    parameter int unsigned VEC_W    = 10,
    parameter int unsigned IDX_W    = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1
);
    logic                      frame_tick;
    logic [7:0]                keycode;
    logic [N_ANGLES*VEC_W-1:0] mot_x_tbl;
    logic [N_ANGLES*VEC_W-1:0] mot_y_tbl;
    logic [IDX_W-1:0]          angle_idx;
    logic [N_ANGLES-1:0]       angle_onehot;
    logic [VEC_W-1:0]          motion_x;
    logic [VEC_W-1:0]          motion_y;
    logic                      step_pulse;
    logic                      limit_pulse;

    modport master (
        output frame_tick, keycode, mot_x_tbl, mot_y_tbl,
        input  angle_idx, angle_onehot, motion_x, motion_y, step_pulse, limit_pulse
    );

    modport slave (
        input  frame_tick, keycode, mot_x_tbl, mot_y_tbl,
        output angle_idx, angle_onehot, motion_x, motion_y, step_pulse, limit_pulse
    );
endinterface

// File: rtl/turret_aim_ctrl.sv
// Turret angle controller: keycode presses and hold-to-repeat step an angle index,
// which selects a one-hot sprite vector and a bullet motion vector from a table.
module turret_aim_ctrl #(
    parameter int unsigned N_ANGLES    = 9,
    parameter int unsigned HOME_IDX    = 4,
    parameter logic [7:0]  KEY_INC     = 8'h51,
    parameter logic [7:0]  KEY_DEC     = 8'h52,
    parameter logic [7:0]  KEY_HOME    = 8'h4A,
    parameter bit          WRAP        = 1'b0,
    parameter int unsigned REPEAT_DLY  = 30,
    parameter int unsigned REPEAT_RATE = 8,
    parameter int unsigned VEC_W       = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    turret_aim_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W   = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1;
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] HOME      = IDX_W'(HOME_IDX);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_ANGLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StHoldDly, StHoldRpt} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_ANGLES-1:0] onehot_q, onehot_d;
    logic [7:0]          key_prev_q;
    logic                step_q, step_d;
    logic                limit_q, limit_d;

    logic is_inc, is_dec, is_home, is_step_key, press, do_step, cnt_wrap;

    assign is_inc      = (bus.keycode == KEY_INC);
    assign is_dec      = (bus.keycode == KEY_DEC);
    assign is_home     = (bus.keycode == KEY_HOME);
    assign is_step_key = is_inc | is_dec;
    // A press is a recognised key that differs from last cycle's keycode, so INC<->DEC
    // without an intervening release also counts as a fresh press.
    assign press       = (is_step_key | is_home) && (bus.keycode != key_prev_q);
    assign cnt_wrap    = (state_q == StHoldDly) ? (cnt_q == DLY_LAST) : (cnt_q == RATE_LAST);

    // Next-state: hold FSM, repeat counter, index arithmetic and event pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        step_d  = 1'b0;
        limit_d = 1'b0;
        do_step = 1'b0;

        if (press && is_step_key) begin
            // Press beats a coincident frame_tick.
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = StHoldDly;
        end else if (press && is_home) begin
            idx_d   = HOME;
            step_d  = (idx_q != HOME);
            cnt_d   = '0;
            state_d = StIdle;
        end else if (!is_step_key) begin
            cnt_d   = '0;
            state_d = StIdle;
        end else if (bus.frame_tick && (state_q != StIdle)) begin
            if (cnt_wrap) begin
                do_step = 1'b1;
                cnt_d   = '0;
                state_d = StHoldRpt;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (do_step) begin
            if (is_inc) begin
                if (idx_q == LAST) begin
                    if (WRAP) begin
                        idx_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    step_d = 1'b1;
                end
            end else begin
                if (idx_q == '0) begin
                    if (WRAP) begin
                        idx_d  = LAST;
                        step_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q - IDX_W'(1);
                    step_d = 1'b1;
                end
            end
        end

        onehot_d = '0;
        for (int i = 0; i < N_ANGLES; i++) begin
            onehot_d[i] = (idx_d == IDX_W'(i));
        end
    end

    // State registers; reset parks the turret at home in IDLE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= HOME;
            onehot_q   <= N_ANGLES'(1) << HOME_IDX;
            key_prev_q <= 8'h00;
            step_q     <= 1'b0;
            limit_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            onehot_q   <= onehot_d;
            key_prev_q <= bus.keycode;
            step_q     <= step_d;
            limit_q    <= limit_d;
        end
    end

    // Motion vector lookup follows the table combinationally from the registered index.
    logic [VEC_W-1:0] motion_x, motion_y;
    always_comb begin
        motion_x = '0;
        motion_y = '0;
        for (int i = 0; i < N_ANGLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                motion_x = bus.mot_x_tbl[i*VEC_W +: VEC_W];
                motion_y = bus.mot_y_tbl[i*VEC_W +: VEC_W];
            end
        end
    end

    assign bus.angle_idx    = idx_q;
    assign bus.angle_onehot = onehot_q;
    assign bus.motion_x     = motion_x;
    assign bus.motion_y     = motion_y;
    assign bus.step_pulse   = step_q;
    assign bus.limit_pulse  = limit_q;
endmodule

// File: tb/tb_turret_aim_ctrl.sv
// Directed bench for turret_aim_ctrl: a saturating and a wrapping instance share stimulus.
module tb_turret_aim_ctrl;
    logic Clk;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    int   step0_cnt = 0, limit0_cnt = 0, step1_cnt = 0;
    int   s_before, l_before;

    turret_aim_ctrl_if #(.N_ANGLES(9), .VEC_W(10)) if0 ();
    turret_aim_ctrl_if #(.N_ANGLES(9), .VEC_W(10)) if1 ();

    turret_aim_ctrl #(.WRAP(1'b0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(if0.slave));
    turret_aim_ctrl #(.WRAP(1'b1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(if1.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count event pulses, one per high cycle.
    always @(posedge Clk) begin
        if (if0.step_pulse)  step0_cnt  <= step0_cnt + 1;
        if (if0.limit_pulse) limit0_cnt <= limit0_cnt + 1;
        if (if1.step_pulse)  step1_cnt  <= step1_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_key(input logic [7:0] k);
        if0.keycode = k;
        if1.keycode = k;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            if0.frame_tick = 1'b1;
            if1.frame_tick = 1'b1;
            cyc(1);
            if0.frame_tick = 1'b0;
            if1.frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic tap(input logic [7:0] k);
        set_key(k);
        cyc(1);
        set_key(8'h00);
        cyc(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0;
        set_key(8'h00);
        if0.frame_tick = 1'b0;
        if1.frame_tick = 1'b0;
        // dx[i] = 16*i+5, dy[i] = -(i+1)
        for (int i = 0; i < 9; i++) begin
            if0.mot_x_tbl[i*10 +: 10] = 10'(16 * i + 5);
            if0.mot_y_tbl[i*10 +: 10] = 10'h3FF - 10'(i);
        end
        if1.mot_x_tbl = if0.mot_x_tbl;
        if1.mot_y_tbl = if0.mot_y_tbl;
        cyc(2);
        chk("rst_idx", 32'(if0.angle_idx), 32'd4);
        chk("rst_onehot", 32'(if0.angle_onehot), 32'h010);
        chk("rst_step", 32'(if0.step_pulse), 32'd0);
        chk("rst_limit", 32'(if0.limit_pulse), 32'd0);
        chk("rst_mx", 32'(if0.motion_x), 32'h045);
        chk("rst_my", 32'(if0.motion_y), 32'h3FB);
        Reset = 1'b1;
        cyc(2);

        // Press INC: one step a cycle later, then no repeat before 30 ticks.
        set_key(8'h51);
        cyc(1);
        chk("press_idx", 32'(if0.angle_idx), 32'd5);
        chk("press_step", 32'(if0.step_pulse), 32'd1);
        chk("press_onehot", 32'(if0.angle_onehot), 32'h020);
        cyc(1);
        chk("press_step_clr", 32'(if0.step_pulse), 32'd0);
        ticks(29);
        chk("dly_29", 32'(if0.angle_idx), 32'd5);
        chk("dly_29_pulses", 32'(step0_cnt), 32'd1);
        ticks(1);
        chk("dly_30", 32'(if0.angle_idx), 32'd6);
        set_key(8'h00);
        cyc(2);

        // Reset mid-hold at idx 7.
        set_key(8'h51);
        cyc(1);
        ticks(5);
        chk("pre_rst_idx", 32'(if0.angle_idx), 32'd7);
        Reset = 1'b0;
        #1;
        chk("mid_rst_idx", 32'(if0.angle_idx), 32'd4);
        chk("mid_rst_onehot", 32'(if0.angle_onehot), 32'h010);
        chk("mid_rst_fsm", 32'(dut0.state_q), 32'd0);
        chk("mid_rst_step", 32'(if0.step_pulse), 32'd0);
        chk("mid_rst_limit", 32'(if0.limit_pulse), 32'd0);
        cyc(1);
        Reset = 1'b1;
        cyc(1);
        // key_prev cleared by reset, so the held key reads as a fresh press.
        chk("post_rst_press", 32'(if0.angle_idx), 32'd5);
        set_key(8'h00);
        cyc(2);

        // Walk down to 0, then DEC at 0: limit (WRAP=0) vs wrap to 8 (WRAP=1).
        for (int i = 0; i < 5; i++) tap(8'h52);
        chk("walk_to_0", 32'(if0.angle_idx), 32'd0);
        set_key(8'h52);
        cyc(1);
        chk("dec_lim_idx", 32'(if0.angle_idx), 32'd0);
        chk("dec_lim_pulse", 32'(if0.limit_pulse), 32'd1);
        chk("dec_lim_step", 32'(if0.step_pulse), 32'd0);
        chk("dec_wrap_idx", 32'(if1.angle_idx), 32'd8);
        chk("dec_wrap_step", 32'(if1.step_pulse), 32'd1);
        set_key(8'h00);
        cyc(2);

        // Hold INC from 0: steps at press, tick 30, tick 38.
        s_before = step0_cnt;
        set_key(8'h51);
        cyc(1);
        chk("rpt_press", 32'(if0.angle_idx), 32'd1);
        ticks(29);
        chk("rpt_t29", 32'(if0.angle_idx), 32'd1);
        ticks(1);
        chk("rpt_t30", 32'(if0.angle_idx), 32'd2);
        ticks(7);
        chk("rpt_t37", 32'(if0.angle_idx), 32'd2);
        ticks(1);
        chk("rpt_t38", 32'(if0.angle_idx), 32'd3);
        chk("rpt_pulses", 32'(step0_cnt - s_before), 32'd3);
        set_key(8'h00);
        cyc(2);

        // Home both, climb to 8, then INC at the top.
        tap(8'h4A);
        chk("home_wrapdut", 32'(if1.angle_idx), 32'd4);
        for (int i = 0; i < 4; i++) tap(8'h51);
        chk("top_idx0", 32'(if0.angle_idx), 32'd8);
        chk("top_idx1", 32'(if1.angle_idx), 32'd8);
        l_before = limit0_cnt;
        set_key(8'h51);
        cyc(1);
        chk("inc_lim_idx", 32'(if0.angle_idx), 32'd8);
        chk("inc_lim_pulse", 32'(if0.limit_pulse), 32'd1);
        chk("inc_lim_step", 32'(if0.step_pulse), 32'd0);
        chk("inc_wrap_idx", 32'(if1.angle_idx), 32'd0);
        chk("inc_wrap_onehot", 32'(if1.angle_onehot), 32'h001);
        chk("inc_wrap_step", 32'(if1.step_pulse), 32'd1);
        cyc(1);
        chk("inc_lim_clr", 32'(if0.limit_pulse), 32'd0);
        ticks(30);
        chk("lim_rpt_count", 32'(limit0_cnt - l_before), 32'd2);
        chk("wrap_rpt_idx", 32'(if1.angle_idx), 32'd1);
        set_key(8'h00);
        cyc(2);

        // INC held, then straight to DEC: immediate step down and the delay restarts.
        tap(8'h4A);
        set_key(8'h51);
        cyc(1);
        chk("sw_inc", 32'(if0.angle_idx), 32'd5);
        ticks(10);
        set_key(8'h52);
        cyc(1);
        chk("sw_dec_idx", 32'(if0.angle_idx), 32'd4);
        chk("sw_dec_step", 32'(if0.step_pulse), 32'd1);
        ticks(29);
        chk("sw_dly_29", 32'(if0.angle_idx), 32'd4);
        ticks(1);
        chk("sw_dly_30", 32'(if0.angle_idx), 32'd3);
        set_key(8'h00);
        cyc(2);

        // HOME from 1, held HOME never repeats, HOME at home is silent.
        tap(8'h52);
        tap(8'h52);
        chk("pre_home", 32'(if0.angle_idx), 32'd1);
        s_before = step0_cnt;
        set_key(8'h4A);
        cyc(1);
        chk("home_idx", 32'(if0.angle_idx), 32'd4);
        chk("home_step", 32'(if0.step_pulse), 32'd1);
        chk("home_mx", 32'(if0.motion_x), 32'h045);
        chk("home_my", 32'(if0.motion_y), 32'h3FB);
        ticks(40);
        chk("home_hold_pulses", 32'(step0_cnt - s_before), 32'd1);
        chk("home_hold_idx", 32'(if0.angle_idx), 32'd4);
        set_key(8'h00);
        cyc(1);
        set_key(8'h4A);
        cyc(1);
        chk("home_at_home_step", 32'(if0.step_pulse), 32'd0);
        chk("home_at_home_lim", 32'(if0.limit_pulse), 32'd0);
        set_key(8'h00);
        cyc(1);

        // Table edit shows up with no clock edge.
        if0.mot_x_tbl[40 +: 10] = 10'h155;
        #1;
        chk("tbl_comb_mx", 32'(if0.motion_x), 32'h155);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
